ipg_rx_extract: RTL and testbench

Receive-side counterpart of the IPG transmit inserter. It consumes 64b/66b encoded receive blocks (header plus 64-bit payload) and pulls IPG message bits out of the control-character slots of control blocks. It reassembles those bits into fixed-width messages and forwards the block stream downstream with the consumed slots restored to idle (zero). It sits between the PCS receive gearbox/block-lock output and the 64b/66b decoder, and presents completed messages to the IPG message processor.

---
 rtl/ipg_rx_extract_if.sv | 33 +++
 rtl/ipg_rx_extract.sv | 133 +++++++++++++
 tb/tb_ipg_rx_extract.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/ipg_rx_extract_if.sv
// Block and message bus for the IPG receive extractor.
//   encoded_rx_*  : incoming 64b/66b blocks (payload, sync header, qualifier)
//   resync        : discard any partially collected message
//   scrubbed_rx_* : outgoing blocks with consumed IPG slots zeroed
//   msg_*         : completed-message handshake toward the IPG message processor
// master = block source / message consumer, slave = the extractor.
interface ipg_rx_extract_if #(
  parameter int unsigned MSG_W = 520
);
  logic [63:0]      encoded_rx_data;
  logic [1:0]       encoded_rx_hdr;
  logic             encoded_rx_valid;
  logic             resync;
  logic [63:0]      scrubbed_rx_data;
  logic [1:0]       scrubbed_rx_hdr;
  logic             scrubbed_rx_valid;
  logic [MSG_W-1:0] msg_data;
  logic             msg_valid;
  logic             msg_ready;
  logic             msg_drop;

  modport master (
    output encoded_rx_data, encoded_rx_hdr, encoded_rx_valid, resync, msg_ready,
    input  scrubbed_rx_data, scrubbed_rx_hdr, scrubbed_rx_valid,
           msg_data, msg_valid, msg_drop
  );

  modport slave (
    input  encoded_rx_data, encoded_rx_hdr, encoded_rx_valid, resync, msg_ready,
    output scrubbed_rx_data, scrubbed_rx_hdr, scrubbed_rx_valid,
           msg_data, msg_valid, msg_drop
  );
endinterface

// File: rtl/ipg_rx_extract.sv
// IPG receive extractor: pulls message bits out of the control-character
// slots of 64b/66b control blocks, reassembles MSG_W-bit messages (first bit
// at the MSB) and forwards the block stream with the consumed slot bits zeroed.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ipg_rx_extract_if.slave (block in/out, resync, message handshake)
// MSG_W must match the interface parameter and lie in 1..1023.
module ipg_rx_extract #(
  parameter int unsigned MSG_W = 520
) (
  input  logic             clk,
  input  logic             rst_n,
  ipg_rx_extract_if.slave  bus
);

  localparam logic [9:0] REM_INIT = 10'(MSG_W);

  logic [9:0]       rem_q, rem_d;
  logic [MSG_W-1:0] acc_q, acc_d;
  logic [63:0]      sdata_q, sdata_d;
  logic [1:0]       shdr_q;
  logic             svalid_q;
  logic [MSG_W-1:0] msg_data_q, msg_data_d;
  logic             msg_valid_q, msg_valid_d;
  logic             msg_drop_q, msg_drop_d;

  // Slot decode: width and lowest bit index of the slot for this block type.
  logic [5:0] slot_n;
  logic [5:0] slot_lo;

  always_comb begin
    // NOTE: every combinational output gets a default first, so unlisted
    // block types decode to an empty slot and no latch is inferred.
    slot_n  = '0;
    slot_lo = '0;
    case (bus.encoded_rx_data[7:0])
      8'h1e:        begin slot_n = 6'd56; slot_lo = 6'd8;  end
      8'h2d, 8'h33: begin slot_n = 6'd24; slot_lo = 6'd8;  end
      8'h4b, 8'hb4: begin slot_n = 6'd24; slot_lo = 6'd40; end
      8'h87:        begin slot_n = 6'd48; slot_lo = 6'd16; end
      8'h99:        begin slot_n = 6'd40; slot_lo = 6'd24; end
      8'haa:        begin slot_n = 6'd32; slot_lo = 6'd32; end
      8'hcc:        begin slot_n = 6'd16; slot_lo = 6'd48; end
      8'hd2:        begin slot_n = 6'd8;  slot_lo = 6'd56; end
      default:      ;
    endcase
  end

  logic             active;
  logic             complete;
  logic [5:0]       take;
  logic [6:0]       shift;
  logic [63:0]      ones;
  logic [63:0]      take_mask;
  logic [63:0]      new_bits;
  logic [MSG_W-1:0] acc_next;

  always_comb begin
    // resync wins over extraction: the block is forwarded but not consumed.
    active   = bus.encoded_rx_valid && (bus.encoded_rx_hdr == 2'b01) && !bus.resync;
    // rem never reaches 0, so an empty slot can never complete a message.
    complete = active && ({4'b0, slot_n} >= rem_q);
    take     = '0;
    if (active) take = complete ? rem_q[5:0] : slot_n;
    // Taken bits are the top 'take' bits of the slot; bits below are left alone.
    shift     = 7'(slot_lo) + 7'(slot_n) - 7'(take);
    ones      = ~({64{1'b1}} << take);
    take_mask = ones << shift;
    new_bits  = (bus.encoded_rx_data >> shift) & ones;
    acc_next  = (acc_q << take) | MSG_W'(new_bits);
  end

  always_comb begin
    rem_d = rem_q;
    acc_d = acc_q;
    if (bus.resync || complete) begin
      rem_d = REM_INIT;
      acc_d = '0;
    end else if (active) begin
      rem_d = rem_q - {4'b0, take};
      acc_d = acc_next;
    end

    msg_data_d  = msg_data_q;
    msg_valid_d = msg_valid_q;
    msg_drop_d  = 1'b0;
    if (msg_valid_q && bus.msg_ready) msg_valid_d = 1'b0;
    if (complete) begin
      // The holding register is free if empty or being accepted this cycle.
      if (!msg_valid_q || bus.msg_ready) begin
        msg_data_d  = acc_next;
        msg_valid_d = 1'b1;
      end else begin
        msg_drop_d = 1'b1;
      end
    end

    sdata_d = bus.encoded_rx_data & ~take_mask;
  end

  // NOTE: the accumulator and message register are plain flops, not RAM, so
  // they are reset; that is what makes a mid-message reset discard the partial.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q       <= REM_INIT;
      acc_q       <= '0;
      sdata_q     <= '0;
      shdr_q      <= '0;
      svalid_q    <= 1'b0;
      msg_data_q  <= '0;
      msg_valid_q <= 1'b0;
      msg_drop_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      rem_q       <= rem_d;
      acc_q       <= acc_d;
      sdata_q     <= sdata_d;
      shdr_q      <= bus.encoded_rx_hdr;
      svalid_q    <= bus.encoded_rx_valid;
      msg_data_q  <= msg_data_d;
      msg_valid_q <= msg_valid_d;
      msg_drop_q  <= msg_drop_d;
    end
  end

  assign bus.scrubbed_rx_data  = sdata_q;
  assign bus.scrubbed_rx_hdr   = shdr_q;
  assign bus.scrubbed_rx_valid = svalid_q;
  assign bus.msg_data          = msg_data_q;
  assign bus.msg_valid         = msg_valid_q;
  assign bus.msg_drop          = msg_drop_q;

endmodule

// File: tb/tb_ipg_rx_extract.sv
// Directed bench for ipg_rx_extract with MSG_W=520: a vector table for the
// mixed block-type walk plus hand-written message, drop, resync and reset runs.
module tb_ipg_rx_extract;
  localparam int MSG_W = 520;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ipg_rx_extract_if #(.MSG_W(MSG_W)) bus ();

  ipg_rx_extract #(.MSG_W(MSG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  hdr;
    logic [63:0] data;
    logic        vld;
    logic [63:0] exp_data;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, 1024'(act), 1024'(exp));
  endtask

  task automatic check_64(input string name, input logic [63:0] act, input logic [63:0] exp);
    check(name, 1024'(act), 1024'(exp));
  endtask

  task automatic check_msg(input string name, input logic [MSG_W-1:0] act, input logic [MSG_W-1:0] exp);
    check(name, 1024'(act), 1024'(exp));
  endtask

  // Drive one block at a negedge; on return the block's output is visible.
  task automatic apply(input logic [1:0] hdr, input logic [63:0] data, input logic vld, input logic rs);
    bus.encoded_rx_hdr   = hdr;
    bus.encoded_rx_data  = data;
    bus.encoded_rx_valid = vld;
    bus.resync           = rs;
    @(negedge clk);
  endtask

  task automatic idle();
    apply(2'b00, 64'h0, 1'b0, 1'b0);
  endtask

  function automatic logic [63:0] blk1e(input logic [55:0] s);
    return {s, 8'h1e};
  endfunction

  // Slot contents for block k of a 10-block 0x1e message; block 9 carries the
  // last 16 message bits on top and filler below.
  function automatic logic [55:0] slot_of(input logic [MSG_W-1:0] m, input int k, input logic [39:0] fill);
    if (k < 9) return m[519-56*k -: 56];
    return {m[15:0], fill};
  endfunction

  task automatic send_msg(input logic [MSG_W-1:0] m, input logic [39:0] fill, input int first, input int last);
    for (int k = first; k <= last; k++) apply(2'b01, blk1e(slot_of(m, k, fill)), 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t             vecs [9];
    logic [MSG_W-1:0] pat, msg_a, msg_b, em;
    logic [39:0]      fill;
    logic [55:0]      s;

    pat = '0;
    for (int i = 0; i < 65; i++) pat = {pat[511:0], 8'(i * 37 + 11)};
    fill = 40'hAB_CDEF_0123;

    vecs[0] = '{"cc",    2'b01, 64'hC0DE_1122_3344_55CC, 1'b1, 64'h0000_1122_3344_55CC};
    vecs[1] = '{"33",    2'b01, 64'h89AB_CDEF_7654_3233, 1'b1, 64'h89AB_CDEF_0000_0033};
    vecs[2] = '{"87",    2'b01, 64'hFEDC_BA98_7654_AA87, 1'b1, 64'h0000_0000_0000_AA87};
    vecs[3] = '{"78",    2'b01, 64'h1111_2222_3333_4478, 1'b1, 64'h1111_2222_3333_4478};
    vecs[4] = '{"data",  2'b10, 64'h0123_4567_89AB_CDEF, 1'b1, 64'h0123_4567_89AB_CDEF};
    vecs[5] = '{"hdr00", 2'b00, 64'hFFFF_FFFF_FFFF_FF1E, 1'b1, 64'hFFFF_FFFF_FFFF_FF1E};
    vecs[6] = '{"hdr11", 2'b11, 64'hEEEE_EEEE_EEEE_EE1E, 1'b1, 64'hEEEE_EEEE_EEEE_EE1E};
    vecs[7] = '{"vld0",  2'b01, 64'hDDDD_DDDD_DDDD_DD1E, 1'b0, 64'hDDDD_DDDD_DDDD_DD1E};
    vecs[8] = '{"d2",    2'b01, 64'h5A66_7788_99AA_BBD2, 1'b1, 64'h0066_7788_99AA_BBD2};

    // Reset state.
    bus.msg_ready        = 1'b1;
    bus.encoded_rx_hdr   = 2'b00;
    bus.encoded_rx_data  = 64'h0;
    bus.encoded_rx_valid = 1'b0;
    bus.resync           = 1'b0;
    repeat (2) @(negedge clk);
    check_64 ("rst_sdata",  bus.scrubbed_rx_data, 64'h0);
    check    ("rst_shdr",   1024'(bus.scrubbed_rx_hdr), 1024'(2'b00));
    check_bit("rst_svalid", bus.scrubbed_rx_valid, 1'b0);
    check_msg("rst_msg",    bus.msg_data, '0);
    check_bit("rst_mvalid", bus.msg_valid, 1'b0);
    check_bit("rst_drop",   bus.msg_drop, 1'b0);
    rst_n = 1'b1;

    // Ten 0x1e blocks carrying the pattern.
    for (int k = 0; k < 10; k++) begin
      apply(2'b01, blk1e(slot_of(pat, k, fill)), 1'b1, 1'b0);
      check_64 ("t1_sdata", bus.scrubbed_rx_data,
                (k < 9) ? {56'h0, 8'h1e} : {16'h0, fill, 8'h1e});
      check_bit("t1_mvalid", bus.msg_valid, k == 9);
    end
    check    ("t1_shdr",   1024'(bus.scrubbed_rx_hdr), 1024'(2'b01));
    check_bit("t1_svalid", bus.scrubbed_rx_valid, 1'b1);
    check_msg("t1_msg",    bus.msg_data, pat);
    check_bit("t1_drop",   bus.msg_drop, 1'b0);
    idle();
    check_bit("t1_accept", bus.msg_valid, 1'b0);

    // Mixed block types from the table; 96 bits are collected (rem 424).
    foreach (vecs[i]) begin
      apply(vecs[i].hdr, vecs[i].data, vecs[i].vld, 1'b0);
      check_64 ({"t2_sdata_", vecs[i].name}, bus.scrubbed_rx_data, vecs[i].exp_data);
      check    ({"t2_shdr_", vecs[i].name}, 1024'(bus.scrubbed_rx_hdr), 1024'(vecs[i].hdr));
      check_bit({"t2_svalid_", vecs[i].name}, bus.scrubbed_rx_valid, vecs[i].vld);
      check_bit({"t2_mvalid_", vecs[i].name}, bus.msg_valid, 1'b0);
    end
    // 424 bits remain: seven full slots (392) then the top 32 bits of an eighth.
    em = MSG_W'(96'hC0DE_7654_32FE_DCBA_9876_545A);
    for (int j = 0; j < 7; j++) begin
      s  = {7{8'(j * 17 + 3)}};
      em = (em << 56) | MSG_W'(s);
      apply(2'b01, blk1e(s), 1'b1, 1'b0);
      check_bit("t2_fill_mvalid", bus.msg_valid, 1'b0);
    end
    em = (em << 32) | MSG_W'(32'hDEAD_BEEF);
    apply(2'b01, blk1e(56'hDEAD_BEEF_12_3456), 1'b1, 1'b0);
    check_64 ("t2_last_sdata", bus.scrubbed_rx_data, 64'h0000_0000_1234_561E);
    check_bit("t2_last_mvalid", bus.msg_valid, 1'b1);
    check_msg("t2_msg", bus.msg_data, em);
    idle();
    check_bit("t2_accept", bus.msg_valid, 1'b0);

    // Message A held, message B dropped.
    bus.msg_ready = 1'b0;
    msg_a = ~pat;
    msg_b = {pat[259:0], pat[519:260]};
    send_msg(msg_a, fill, 0, 9);
    check_bit("t3_a_mvalid", bus.msg_valid, 1'b1);
    check_msg("t3_a_msg", bus.msg_data, msg_a);
    check_bit("t3_a_drop", bus.msg_drop, 1'b0);
    send_msg(msg_b, fill, 0, 8);
    check_bit("t3_b_hold", bus.msg_drop, 1'b0);
    send_msg(msg_b, fill, 9, 9);
    check_bit("t3_b_drop", bus.msg_drop, 1'b1);
    check_bit("t3_b_mvalid", bus.msg_valid, 1'b1);
    check_msg("t3_b_msg", bus.msg_data, msg_a);
    idle();
    check_bit("t3_drop_pulse", bus.msg_drop, 1'b0);
    check_bit("t3_still_valid", bus.msg_valid, 1'b1);
    bus.msg_ready = 1'b1;
    idle();
    check_bit("t3_accept", bus.msg_valid, 1'b0);

    // Completion on the same edge that accepts the previous message.
    bus.msg_ready = 1'b0;
    msg_a = pat ^ {65{8'hC3}};
    msg_b = pat ^ {65{8'h96}};
    send_msg(msg_a, fill, 0, 9);
    check_msg("t4_c_msg", bus.msg_data, msg_a);
    send_msg(msg_b, fill, 0, 8);
    bus.msg_ready = 1'b1;
    send_msg(msg_b, fill, 9, 9);
    check_bit("t4_mvalid", bus.msg_valid, 1'b1);
    check_msg("t4_msg", bus.msg_data, msg_b);
    check_bit("t4_drop", bus.msg_drop, 1'b0);
    idle();
    check_bit("t4_accept", bus.msg_valid, 1'b0);

    // resync after three blocks; the resync-cycle block is not consumed.
    bus.msg_ready = 1'b0;
    for (int j = 0; j < 3; j++) apply(2'b01, blk1e({7{8'h0F}}), 1'b1, 1'b0);
    apply(2'b01, blk1e(56'hAB_CDEF_0123_4567), 1'b1, 1'b1);
    check_64("t5_resync_sdata", bus.scrubbed_rx_data, 64'hABCD_EF01_2345_671E);
    msg_a = pat ^ {65{8'h3C}};
    send_msg(msg_a, fill, 0, 8);
    check_bit("t5_no_early", bus.msg_valid, 1'b0);
    send_msg(msg_a, fill, 9, 9);
    check_bit("t5_mvalid", bus.msg_valid, 1'b1);
    check_msg("t5_msg", bus.msg_data, msg_a);

    // Asynchronous reset mid-message (rem 200) with a message still held.
    for (int j = 0; j < 5; j++) apply(2'b01, blk1e({7{8'h77}}), 1'b1, 1'b0);
    apply(2'b01, 64'h5A66_7788_99AA_BBD2, 1'b1, 1'b0);
    apply(2'b01, 64'h1234_5678_9ABC_DEAA, 1'b1, 1'b0);
    check_64 ("t6_aa_sdata", bus.scrubbed_rx_data, 64'h0000_0000_9ABC_DEAA);
    check_bit("t6_pre_drop", bus.msg_drop, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_64 ("t6_rst_sdata",  bus.scrubbed_rx_data, 64'h0);
    check    ("t6_rst_shdr",   1024'(bus.scrubbed_rx_hdr), 1024'(2'b00));
    check_bit("t6_rst_svalid", bus.scrubbed_rx_valid, 1'b0);
    check_msg("t6_rst_msg",    bus.msg_data, '0);
    check_bit("t6_rst_mvalid", bus.msg_valid, 1'b0);
    check_bit("t6_rst_drop",   bus.msg_drop, 1'b0);
    bus.encoded_rx_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.msg_ready = 1'b1;
    msg_a = pat ^ {65{8'hA5}};
    for (int k = 0; k < 9; k++) begin
      send_msg(msg_a, fill, k, k);
      check_bit("t6_full_needed", bus.msg_valid, 1'b0);
    end
    send_msg(msg_a, fill, 9, 9);
    check_bit("t6_mvalid", bus.msg_valid, 1'b1);
    check_msg("t6_msg", bus.msg_data, msg_a);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
